// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter and the future receiver:
//   parity mode constants, the frame state encoding and the baud divisor
//   calculation.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityOdd  = 1;
  localparam int unsigned ParityEven = 2;

  typedef enum logic [2:0] {
    Idle   = 3'd0,
    Start  = 3'd1,
    Data   = 3'd2,
    Parity = 3'd3,
    Stop   = 3'd4
  } uart_state_e;

  // Clocks per bit period; integer division truncates toward zero.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period timer. Counts 0..Divisor-1 and emits a one-clock tick while the
//   count sits at Divisor-1, then wraps to 0 so consecutive bit periods are
//   back to back. restart_i holds the counter at 0.
// Ports
//   clock      in  rising-edge clock
//   resetN     in  asynchronous active-low reset
//   restart_i  in  synchronous restart, counter forced to 0
//   tick_o     out high for the last clock of each bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned Divisor = 10
) (
  input  logic clock,
  input  logic resetN,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Divisor > 2) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Divisor - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LastCnt)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LastCnt) && !restart_i;

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter: serialises one frame (start bit, DataBits data bits LSB
//   first, optional parity bit, StopBits stop bits) from a parallel word taken
//   on a valid/ready handshake.
// Ports
//   clock    in   rising-edge clock
//   resetN   in   asynchronous active-low reset; aborts any frame in flight
//   txData   in   word to send, sampled only at acceptance
//   txValid  in   source offers txData
//   txReady  out  idle and able to accept (registered)
//   busy     out  frame in progress, start through last stop bit (registered)
//   tx       out  serial line, idle high (registered)
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 1000000,
  parameter int unsigned BaudRate       = 9600,
  parameter int unsigned DataBits       = 8,
  parameter int unsigned ParityMode     = 0,
  parameter int unsigned StopBits       = 1
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [DataBits-1:0] txData,
  input  logic                txValid,
  output logic                txReady,
  output logic                busy,
  output logic                tx
);

  localparam int unsigned Divisor = calc_divisor(ClockFrequency, BaudRate);
  localparam int unsigned BitCntW = $clog2(DataBits + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DataBits - 1);

  if ((DataBits < 5) || (DataBits > 9)) begin : g_err_databits
    $error("uart_tx_frame: DataBits must be in 5..9");
  end
  if (ParityMode > ParityEven) begin : g_err_parity
    $error("uart_tx_frame: ParityMode must be 0, 1 or 2");
  end
  if ((StopBits < 1) || (StopBits > 2)) begin : g_err_stop
    $error("uart_tx_frame: StopBits must be 1 or 2");
  end
  if (Divisor < 2) begin : g_err_divisor
    $error("uart_tx_frame: ClockFrequency/BaudRate must be at least 2");
  end

  uart_state_e         state_q;
  logic [DataBits-1:0] shift_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic                stop_cnt_q;
  logic                parity_q;
  logic                tx_q;
  logic                ready_q;
  logic                busy_q;

  logic baud_tick;
  logic baud_restart;

  // The timer is parked at 0 while idle, so the first start-bit period is a
  // full Divisor clocks from the acceptance edge. Every later state or bit
  // change happens on a tick, where the timer wraps to 0 by itself.
  assign baud_restart = (state_q == Idle);

  uart_baud_tick #(
    .Divisor(Divisor)
  ) u_baud_tick (
    .clock    (clock),
    .resetN   (resetN),
    .restart_i(baud_restart),
    .tick_o   (baud_tick)
  );

  function automatic logic parity_of(input logic [DataBits-1:0] d);
    return (ParityMode == ParityOdd) ? ~^d : ^d;
  endfunction

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= Idle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (txValid && ready_q) begin
            shift_q  <= txData;
            parity_q <= parity_of(txData);
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= Start;
          end
        end

        Start: begin
          if (baud_tick) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= Data;
          end
        end

        Data: begin
          if (baud_tick) begin
            if (bit_cnt_q == LastBit) begin
              if (ParityMode != ParityNone) begin
                tx_q    <= parity_q;
                state_q <= Parity;
              end else begin
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= Stop;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        Parity: begin
          if (baud_tick) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= Stop;
          end
        end

        Stop: begin
          if (baud_tick) begin
            // Ready rises on the final stop tick; the earliest next acceptance
            // is the following edge, which yields the one-clock idle gap.
            if (stop_cnt_q == 1'(StopBits - 1)) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= Idle;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= Idle;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign txReady = ready_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Four transmitter configurations on a shared clock and reset:
//     0: 8N1, Divisor 10     1: 7E2, Divisor 10
//     2: 7O2, Divisor 10     3: 9N1, Divisor 4
//   The expected line level for every clock is taken from a list of frame bits
//   (start, data LSB first, parity from a ones count, stop bits), each bit
//   lasting Divisor clocks.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int DB [4] = '{8, 7, 7, 9};
  localparam int PM [4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 2, 2, 1};
  localparam int DV [4] = '{10, 10, 10, 4};

  logic       clock;
  logic       resetN;
  logic [3:0] valid_r;
  logic [8:0] data_r [4];
  logic [3:0] tx_w;
  logic [3:0] ready_w;
  logic [3:0] busy_w;

  int n_cmp;
  int n_err;

  uart_tx_frame #(
    .ClockFrequency(1000000), .BaudRate(100000),
    .DataBits(8), .ParityMode(0), .StopBits(1)
  ) u0 (
    .clock(clock), .resetN(resetN), .txData(data_r[0][7:0]), .txValid(valid_r[0]),
    .txReady(ready_w[0]), .busy(busy_w[0]), .tx(tx_w[0])
  );

  uart_tx_frame #(
    .ClockFrequency(1000000), .BaudRate(100000),
    .DataBits(7), .ParityMode(2), .StopBits(2)
  ) u1 (
    .clock(clock), .resetN(resetN), .txData(data_r[1][6:0]), .txValid(valid_r[1]),
    .txReady(ready_w[1]), .busy(busy_w[1]), .tx(tx_w[1])
  );

  uart_tx_frame #(
    .ClockFrequency(1000000), .BaudRate(100000),
    .DataBits(7), .ParityMode(1), .StopBits(2)
  ) u2 (
    .clock(clock), .resetN(resetN), .txData(data_r[2][6:0]), .txValid(valid_r[2]),
    .txReady(ready_w[2]), .busy(busy_w[2]), .tx(tx_w[2])
  );

  uart_tx_frame #(
    .ClockFrequency(1000000), .BaudRate(250000),
    .DataBits(9), .ParityMode(0), .StopBits(1)
  ) u3 (
    .clock(clock), .resetN(resetN), .txData(data_r[3]), .txValid(valid_r[3]),
    .txReady(ready_w[3]), .busy(busy_w[3]), .tx(tx_w[3])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s tx u%0d", tag, i), 32'(tx_w[i]), 32'd1);
      check_eq($sformatf("%s ready u%0d", tag, i), 32'(ready_w[i]), 32'd1);
      check_eq($sformatf("%s busy u%0d", tag, i), 32'(busy_w[i]), 32'd0);
    end
  endtask

  // Sends one frame on instance idx and checks every clock of it.
  //   preset    : valid/data already driven by the previous (chained) frame
  //   chain     : keep valid high and offer next_d for a back-to-back frame
  //   abort_at  : clock index at which reset is pulsed mid-frame (-1 = none)
  task automatic send_frame(input int idx, input logic [8:0] d, input bit preset,
                            input bit chain, input logic [8:0] next_d, input int abort_at);
    bit exp_q[$];
    int ones;
    int len;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB[idx]; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PM[idx] == 1) exp_q.push_back((ones % 2) == 0);
    else if (PM[idx] == 2) exp_q.push_back((ones % 2) == 1);
    for (int i = 0; i < SB[idx]; i++) exp_q.push_back(1'b1);
    len = exp_q.size() * DV[idx];

    if (!preset) begin
      @(negedge clock);
      valid_r[idx] = 1'b1;
      data_r[idx]  = d;
    end
    check_eq($sformatf("pre tx u%0d", idx), 32'(tx_w[idx]), 32'd1);
    check_eq($sformatf("pre ready u%0d", idx), 32'(ready_w[idx]), 32'd1);
    @(posedge clock);

    for (int k = 0; k < len; k++) begin
      @(negedge clock);
      check_eq($sformatf("tx u%0d d%0h k%0d", idx, d, k), 32'(tx_w[idx]),
               32'(exp_q[k / DV[idx]]));
      check_eq($sformatf("ready u%0d k%0d", idx, k), 32'(ready_w[idx]), 32'd0);
      check_eq($sformatf("busy u%0d k%0d", idx, k), 32'(busy_w[idx]), 32'd1);
      if (k == abort_at) begin
        valid_r[idx] = 1'b0;
        #2 resetN = 1'b0;
        #1;
        check_eq($sformatf("abort tx u%0d", idx), 32'(tx_w[idx]), 32'd1);
        check_eq($sformatf("abort busy u%0d", idx), 32'(busy_w[idx]), 32'd0);
        check_eq($sformatf("abort ready u%0d", idx), 32'(ready_w[idx]), 32'd1);
        @(negedge clock);
        check_idle_all("in reset");
        resetN = 1'b1;
        return;
      end
      if (chain) begin
        valid_r[idx] = 1'b1;
        data_r[idx]  = next_d;
      end else if (k == len - 1) begin
        valid_r[idx] = 1'b0;
      end else begin
        // Mid-frame valid pulses and data changes must not disturb the frame.
        valid_r[idx] = 1'($urandom_range(0, 1));
        data_r[idx]  = 9'($urandom);
      end
    end

    @(negedge clock);
    check_eq($sformatf("end tx u%0d", idx), 32'(tx_w[idx]), 32'd1);
    check_eq($sformatf("end ready u%0d", idx), 32'(ready_w[idx]), 32'd1);
    check_eq($sformatf("end busy u%0d", idx), 32'(busy_w[idx]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    resetN  = 1'b0;
    valid_r = '0;
    for (int i = 0; i < 4; i++) data_r[i] = '0;

    // Reset held: valid offers are ignored and the line stays idle.
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      valid_r = 4'b1111;
      data_r[0] = 9'h0A5;
      check_idle_all("reset held");
    end
    @(negedge clock);
    valid_r = '0;
    resetN  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_idle_all("after release");
    end

    // 8N1 fixed pattern.
    send_frame(0, 9'h0A5, 1'b0, 1'b0, 9'h000, -1);

    // 7E2 and 7O2 with 7'h03, then random words.
    send_frame(1, 9'h003, 1'b0, 1'b0, 9'h000, -1);
    send_frame(2, 9'h003, 1'b0, 1'b0, 9'h000, -1);
    for (int r = 0; r < 3; r++) begin
      send_frame(1, 9'($urandom), 1'b0, 1'b0, 9'h000, -1);
      send_frame(2, 9'($urandom), 1'b0, 1'b0, 9'h000, -1);
    end

    // Back-to-back with valid held high: 8'h55 then 8'hAA.
    send_frame(0, 9'h055, 1'b0, 1'b1, 9'h0AA, -1);
    send_frame(0, 9'h0AA, 1'b1, 1'b0, 9'h000, -1);

    // Reset during data bit 3 (clocks 40..49 of the frame), then a fresh frame.
    send_frame(0, 9'($urandom), 1'b0, 1'b0, 9'h000, 44);
    @(negedge clock);
    check_idle_all("post abort");
    send_frame(0, 9'($urandom), 1'b0, 1'b0, 9'h000, -1);

    // 9 data bits at Divisor 4.
    send_frame(3, 9'h1FF, 1'b0, 1'b0, 9'h000, -1);

    // Random frames across all configurations, some chained.
    for (int r = 0; r < 8; r++) begin
      int idx;
      logic [8:0] d0;
      logic [8:0] d1;
      idx = int'($urandom_range(0, 3));
      d0  = 9'($urandom);
      d1  = 9'($urandom);
      if ((r % 2) == 1) begin
        send_frame(idx, d0, 1'b0, 1'b1, d1, -1);
        send_frame(idx, d1, 1'b1, 1'b0, 9'h000, -1);
      end else begin
        send_frame(idx, d0, 1'b0, 1'b0, 9'h000, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
